mem_dump: RTL

- Post-run state reader for the single-cycle CPU. Given a start pulse, a base word address and a word count, it sequentially reads words from a RAM or register-file read port.
- Each word goes out on a valid/ready stream toward a monitor, UART, or bench scoreboard.
- While a dump is in progress it holds the CPU frozen so memory contents are stable.
- It is the read-out counterpart of the memory/register preload path.

---
 rtl/mem_dump_pkg.sv | 16 +
 rtl/mem_dump_if.sv | 26 ++
 rtl/mem_dump_addr_gen.sv | 35 +++
 rtl/mem_dump.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// mem_dump shared types: FSM state encoding and default widths.
// Defaults match the data RAM (8-bit word address, 32-bit words).
package mem_dump_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_dump_if.sv
// Word stream from mem_dump to a monitor/UART/scoreboard.
// Ports: valid, ready, data, addr (source address), last.
interface mem_dump_if
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              last;

  modport master (
    output valid, data, addr, last,
    input  ready
  );

  modport slave (
    input  valid, data, addr, last,
    output ready
  );

endinterface

// File: rtl/mem_dump_addr_gen.sv
// dump_addr_gen: word address and remaining-count counters.
// Ports: clk, rst, load (base/cnt), step (+1/-1), addr, last.
module dump_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [CNT_W-1:0]  cnt,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [CNT_W-1:0] remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= cnt;
    end else if (step) begin
      // address wraps naturally modulo 2^ADDR_W
      addr      <= addr + ADDR_W'(1);
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/mem_dump.sv
// mem_dump: reads word_cnt words from base_addr and streams them out,
// freezing the CPU meanwhile. Optional DUMP_CHECKSUM_EN adds checksum.
// Ports: clk, rst, start, base_addr, word_cnt, busy, cpu_freeze,
// rd_addr, rd_data, out (stream master), done [, checksum].
module mem_dump
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  output logic              busy,
  output logic              cpu_freeze,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  mem_dump_if.master        out,
  output logic              done
`ifdef DUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_t state, nxt;

  logic              load;
  logic              step;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_last;

  logic              v_q;
  logic [DATA_W-1:0] d_q;
  logic [ADDR_W-1:0] a_q;
  logic              l_q;

  wire hs = v_q && out.ready;

  dump_addr_gen #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_ag (
    .clk (clk),
    .rst (rst),
    .load(load),
    .step(step),
    .base(base_addr),
    .cnt (word_cnt),
    .addr(ag_addr),
    .last(ag_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    step = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (word_cnt != '0) begin
            load = 1'b1;
            nxt  = READ;
          end else begin
            nxt  = FIN;
          end
        end
      end
      READ: nxt = SEND;
      SEND: begin
        if (hs) begin
          step = 1'b1;
          nxt  = l_q ? FIN : READ;
        end
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      d_q <= '0;
      a_q <= '0;
      l_q <= 1'b0;
    end else if (state == READ) begin
      v_q <= 1'b1;
      d_q <= rd_data;
      a_q <= ag_addr;
      l_q <= ag_last;
    end else if (step) begin
      v_q <= 1'b0;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)
      checksum <= '0;
    else if (state == IDLE && start)
      checksum <= '0;
    else if (step)
      checksum <= checksum + d_q;
  end
`endif

  assign out.valid  = v_q;
  assign out.data   = d_q;
  assign out.addr   = a_q;
  assign out.last   = l_q;
  assign rd_addr    = ag_addr;
  assign busy       = (state != IDLE);
  assign cpu_freeze = busy;
  assign done       = (state == FIN);

endmodule
